accel_spi_reader: RTL and testbench

SPI master that initialises a 3-axis accelerometer, polls its X/Y/Z data registers continuously, and presents scaled axis values to the top-level wrapper. The wrapper uses these values for tilt detection (up/down/left/right/rest) and player control. It drives the board `sclk`/`mosi`/`ss` pins, samples `miso`, and outputs `accel_x`, `accel_y`, `accel_z` plus a one-cycle `data_valid` strobe.

---
 rtl/accel_spi_reader.sv | 212 +++++++++++++++++++++
 tb/tb_accel_spi_reader.sv | 304 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/accel_spi_reader.sv
`default_nettype none
// ============================================================================
// Module   : accel_spi_reader
// Brief    : SPI mode-0 master that configures a 3-axis accelerometer once per
//            reset, then polls X/Y/Z forever and presents scaled axis values.
//            Define ACCEL_AVG_EN to average each axis over pairs of reads.
// Revision : 1.0
// ============================================================================
module accel_spi_reader #(
    parameter int CLK_DIV      = 50,
    parameter int POWERUP_WAIT = 100000,
    parameter int SAMPLE_GAP   = 1000
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        miso,
    output logic        sclk,
    output logic        mosi,
    output logic        ss,
    output logic [8:0]  accel_x,
    output logic [8:0]  accel_y,
    output logic [11:0] accel_z,
    output logic        data_valid
);
    localparam int c_CNT_MAX = (POWERUP_WAIT > SAMPLE_GAP) ? POWERUP_WAIT : SAMPLE_GAP;
    localparam int c_CNT_W   = $clog2(c_CNT_MAX + 1);
    localparam int c_DIV_W   = $clog2(CLK_DIV + 1);

    localparam logic [2:0] S_WAIT  = 3'd0;
    localparam logic [2:0] S_CFG   = 3'd1;
    localparam logic [2:0] S_GAP   = 3'd2;
    localparam logic [2:0] S_RD    = 3'd3;
    localparam logic [2:0] S_LATCH = 3'd4;

    // Frames are left-aligned so both transactions shift out of bit 63.
    localparam logic [63:0] c_CFG_FRAME = {24'h0A2D02, 40'd0};
    localparam logic [63:0] c_RD_FRAME  = {16'h0B0E, 48'd0};
    localparam logic [7:0]  c_CFG_LAST  = 8'd48;
    localparam logic [7:0]  c_RD_LAST   = 8'd128;

    logic [2:0]         r_state;
    logic [c_CNT_W-1:0] r_cnt;
    logic [c_DIV_W-1:0] r_div_cnt;
    logic [7:0]         r_half_cnt;
    logic [63:0]        r_tx;
    logic [47:0]        r_rx;

    logic        w_in_xfer;
    logic        w_tick;
    logic        w_last;
    logic        w_end;
    logic        w_wait_done;
    logic        w_gap_done;
    logic        w_start;
    logic        w_latch;
    logic [63:0] w_frame;
    logic [11:0] w_x_word;
    logic [11:0] w_y_word;
    logic [11:0] w_z_word;
    logic [8:0]  w_new_x;
    logic [8:0]  w_new_y;
    logic [11:0] w_new_z;
    logic        w_fire;

    assign w_in_xfer   = (r_state == S_CFG) || (r_state == S_RD);
    assign w_tick      = w_in_xfer && (r_div_cnt == c_DIV_W'(CLK_DIV - 1));
    assign w_last      = (r_state == S_RD) ? (r_half_cnt == c_RD_LAST) : (r_half_cnt == c_CFG_LAST);
    assign w_end       = w_tick && w_last;
    assign w_wait_done = (r_state == S_WAIT) && (r_cnt == c_CNT_W'(POWERUP_WAIT - 1));
    assign w_gap_done  = (r_state == S_GAP) && (r_cnt == c_CNT_W'(SAMPLE_GAP - 1));
    assign w_start     = w_wait_done || w_gap_done;
    assign w_latch     = (r_state == S_LATCH);
    assign w_frame     = (r_state == S_WAIT) ? c_CFG_FRAME : c_RD_FRAME;

    // Received bytes 2..7 end up as XL XH YL YH ZL ZH in r_rx[47:0].
    assign w_x_word = {r_rx[35:32], r_rx[47:40]};
    assign w_y_word = {r_rx[19:16], r_rx[31:24]};
    assign w_z_word = {r_rx[3:0],   r_rx[15:8]};

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            ss         <= 1'b1;
            sclk       <= 1'b0;
            mosi       <= 1'b0;
            r_tx       <= '0;
            r_rx       <= '0;
            r_div_cnt  <= '0;
            r_half_cnt <= '0;
        end else if (w_start) begin
            ss         <= 1'b0;
            mosi       <= w_frame[63];
            r_tx       <= {w_frame[62:0], 1'b0};
            r_div_cnt  <= '0;
            r_half_cnt <= '0;
        end else if (w_tick) begin
            r_div_cnt  <= '0;
            r_half_cnt <= r_half_cnt + 8'd1;
            if (w_last) begin
                ss   <= 1'b1;
                mosi <= 1'b0;
            end else if (!r_half_cnt[0]) begin
                sclk <= 1'b1;
                r_rx <= {r_rx[46:0], miso};
            end else begin
                sclk <= 1'b0;
                mosi <= r_tx[63];
                r_tx <= {r_tx[62:0], 1'b0};
            end
        end else if (w_in_xfer) begin
            r_div_cnt <= r_div_cnt + c_DIV_W'(1);
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state <= S_WAIT;
            r_cnt   <= '0;
        end else begin
            case (r_state)
                S_WAIT: begin
                    if (w_wait_done) begin
                        r_state <= S_CFG;
                        r_cnt   <= '0;
                    end else begin
                        r_cnt <= r_cnt + c_CNT_W'(1);
                    end
                end
                S_CFG:   if (w_end) r_state <= S_GAP;
                S_GAP: begin
                    if (w_gap_done) begin
                        r_state <= S_RD;
                        r_cnt   <= '0;
                    end else begin
                        r_cnt <= r_cnt + c_CNT_W'(1);
                    end
                end
                S_RD:    if (w_end) r_state <= S_LATCH;
                S_LATCH: r_state <= S_GAP;
                default: r_state <= S_WAIT;
            endcase
        end
    end

`ifdef ACCEL_AVG_EN
    logic        r_avg_phase;
    logic [11:0] r_acc_x;
    logic [11:0] r_acc_y;
    logic [11:0] r_acc_z;
    logic [12:0] w_sum_x;
    logic [12:0] w_sum_y;
    logic [12:0] w_sum_z;
    logic [11:0] w_avg_x;
    logic [11:0] w_avg_y;
    logic        w_unused;

    assign w_sum_x  = {w_x_word[11], w_x_word} + {r_acc_x[11], r_acc_x};
    assign w_sum_y  = {w_y_word[11], w_y_word} + {r_acc_y[11], r_acc_y};
    assign w_sum_z  = {w_z_word[11], w_z_word} + {r_acc_z[11], r_acc_z};
    assign w_avg_x  = w_sum_x[12:1];
    assign w_avg_y  = w_sum_y[12:1];
    assign w_new_x  = {~w_avg_x[11], w_avg_x[10:3]};
    assign w_new_y  = {~w_avg_y[11], w_avg_y[10:3]};
    assign w_new_z  = w_sum_z[12:1];
    assign w_fire   = r_avg_phase;
    assign w_unused = ^{r_rx[39:36], r_rx[23:20], r_rx[7:4], w_sum_x[0], w_sum_y[0],
                        w_sum_z[0], w_avg_x[2:0], w_avg_y[2:0]};

    // First read of each pair only parks its words in the accumulator.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_avg_phase <= 1'b0;
            r_acc_x     <= '0;
            r_acc_y     <= '0;
            r_acc_z     <= '0;
        end else if (w_latch) begin
            r_avg_phase <= ~r_avg_phase;
            if (!r_avg_phase) begin
                r_acc_x <= w_x_word;
                r_acc_y <= w_y_word;
                r_acc_z <= w_z_word;
            end
        end
    end
`else
    logic w_unused;

    assign w_new_x  = {~w_x_word[11], w_x_word[10:3]};
    assign w_new_y  = {~w_y_word[11], w_y_word[10:3]};
    assign w_new_z  = w_z_word;
    assign w_fire   = 1'b1;
    assign w_unused = ^{r_rx[39:36], r_rx[23:20], r_rx[7:4], w_x_word[2:0], w_y_word[2:0]};
`endif

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            accel_x    <= '0;
            accel_y    <= '0;
            accel_z    <= '0;
            data_valid <= 1'b0;
        end else begin
            data_valid <= 1'b0;
            if (w_latch && w_fire) begin
                accel_x    <= w_new_x;
                accel_y    <= w_new_y;
                accel_z    <= w_new_z;
                data_valid <= 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_accel_spi_reader.sv
`default_nettype none
// ============================================================================
// Module   : tb_accel_spi_reader
// Brief    : Sensor model plus scoreboard bench for accel_spi_reader.
// Revision : 1.0
// ============================================================================
module tb_accel_spi_reader;
    localparam int CLK_DIV      = 4;
    localparam int POWERUP_WAIT = 10;
    localparam int SAMPLE_GAP   = 20;
    localparam int RD_LAT       = 129 * CLK_DIV + 1;
`ifdef ACCEL_AVG_EN
    localparam int DV_PERIOD    = 2 * (129 * CLK_DIV + SAMPLE_GAP + 1);
`else
    localparam int DV_PERIOD    = 129 * CLK_DIV + SAMPLE_GAP + 1;
`endif

    logic        clk   = 1'b0;
    logic        rst_n = 1'b1;
    logic        miso  = 1'b0;
    logic        sclk;
    logic        mosi;
    logic        ss;
    logic [8:0]  accel_x;
    logic [8:0]  accel_y;
    logic [11:0] accel_z;
    logic        data_valid;

    accel_spi_reader #(
        .CLK_DIV      (CLK_DIV),
        .POWERUP_WAIT (POWERUP_WAIT),
        .SAMPLE_GAP   (SAMPLE_GAP)
    ) dut (
        .clock      (clk),
        .reset      (rst_n),
        .miso       (miso),
        .sclk       (sclk),
        .mosi       (mosi),
        .ss         (ss),
        .accel_x    (accel_x),
        .accel_y    (accel_y),
        .accel_z    (accel_z),
        .data_valid (data_valid)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct packed {
        logic [8:0]  x;
        logic [8:0]  y;
        logic [11:0] z;
    } exp_t;

    exp_t q_exp[$];
    int   n_checks = 0;
    int   n_pass   = 0;

    function automatic void check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    endfunction

    function automatic int to_signed12(input logic [11:0] v);
        return v[11] ? int'(v) - 4096 : int'(v);
    endfunction

    // Tilt code: floor(value / 8) re-centred so that level reads 256.
    function automatic logic [8:0] tilt_code(input int s);
        int t;
        t = (s >>> 3) + 256;
        return t[8:0];
    endfunction

    task automatic pick_vec(input int idx, output logic [11:0] vx, output logic [11:0] vy,
                            output logic [11:0] vz);
        vx = 12'h0F0;
        vy = 12'hF80;
        vz = 12'h3E8;
`ifdef ACCEL_AVG_EN
        if (idx == 0) vx = 12'h100;
        else if (idx == 1) vx = 12'h102;
`endif
        if (idx == 6) begin
            vx = 12'h800; vy = 12'h7FF; vz = 12'h800;
        end else if (idx == 7) begin
            vx = 12'h7FF; vy = 12'h000; vz = 12'hFFF;
        end else if (idx >= 8) begin
            vx = 12'($urandom_range(0, 4095));
            vy = 12'($urandom_range(0, 4095));
            vz = 12'($urandom_range(0, 4095));
        end
    endtask

    // ---------------- sensor model / stimulus ----------------
    logic        s_active    = 1'b0;
    logic        expect_cfg  = 1'b1;
    logic        avg_pending = 1'b0;
    logic        p_ss        = 1'b1;
    logic        p_sclk      = 1'b0;
    int          nbits       = 0;
    int          s_fall_cyc  = 0;
    int          rd_idx      = 0;
    int          rd_done     = 0;
    int          acc_x, acc_y, acc_z, sx, sy, sz;
    logic [63:0] mosi_bits;
    logic [63:0] resp;
    logic [11:0] cur_x, cur_y, cur_z;
    logic [3:0]  jn;
    exp_t        e_push;

    always @(negedge clk) begin
        if (!rst_n) begin
            s_active    = 1'b0;
            expect_cfg  = 1'b1;
            avg_pending = 1'b0;
            p_ss        = 1'b1;
            p_sclk      = 1'b0;
            miso        = 1'b0;
            q_exp.delete();
        end else begin
            if (p_ss && !ss) begin
                s_active   = 1'b1;
                nbits      = 0;
                mosi_bits  = '0;
                s_fall_cyc = cyc;
                if (expect_cfg) begin
                    resp = {$urandom, $urandom};
                end else begin
                    pick_vec(rd_idx, cur_x, cur_y, cur_z);
                    jn   = (rd_idx < 6) ? 4'hF : 4'($urandom);
                    resp = {8'($urandom), 8'($urandom), cur_x[7:0], jn, cur_x[11:8],
                            cur_y[7:0], jn, cur_y[11:8], cur_z[7:0], jn, cur_z[11:8]};
                end
                miso = resp[63];
            end else if (!ss && s_active) begin
                if (!p_sclk && sclk) begin
                    mosi_bits = {mosi_bits[62:0], mosi};
                    nbits++;
                end else if (p_sclk && !sclk && nbits < 64) begin
                    miso = resp[63 - nbits];
                end
            end else if (!p_ss && ss && s_active) begin
                s_active = 1'b0;
                if (expect_cfg) begin
                    check("cfg_len", 64'(nbits), 64'd24);
                    check("cfg_cmd", mosi_bits, 64'h0A2D02);
                    check("cfg_ss_low", 64'(cyc - s_fall_cyc), 64'(49 * CLK_DIV));
                    expect_cfg = 1'b0;
                end else begin
                    check("rd_len", 64'(nbits), 64'd64);
                    check("rd_cmd", mosi_bits, 64'h0B0E_0000_0000_0000);
                    check("rd_ss_low", 64'(cyc - s_fall_cyc), 64'(129 * CLK_DIV));
                    sx = to_signed12(cur_x);
                    sy = to_signed12(cur_y);
                    sz = to_signed12(cur_z);
`ifdef ACCEL_AVG_EN
                    if (!avg_pending) begin
                        acc_x = sx; acc_y = sy; acc_z = sz;
                        avg_pending = 1'b1;
                    end else begin
                        sx = (acc_x + sx) >>> 1;
                        sy = (acc_y + sy) >>> 1;
                        sz = (acc_z + sz) >>> 1;
                        e_push = '{x: tilt_code(sx), y: tilt_code(sy), z: 12'(sz)};
                        q_exp.push_back(e_push);
                        avg_pending = 1'b0;
                    end
`else
                    e_push = '{x: tilt_code(sx), y: tilt_code(sy), z: 12'(sz)};
                    q_exp.push_back(e_push);
`endif
                    rd_idx++;
                    rd_done++;
                end
            end
            p_ss   = ss;
            p_sclk = sclk;
        end
    end

    // ---------------- monitor / scoreboard ----------------
    logic        m_in_rst     = 1'b1;
    logic        m_prev_ok    = 1'b0;
    logic        m_first_fall = 1'b1;
    logic        m_dv_seen    = 1'b0;
    logic        m_pss        = 1'b1;
    logic        m_psclk      = 1'b0;
    logic        m_pmosi      = 1'b0;
    logic        m_pdv        = 1'b0;
    logic [29:0] m_pout       = '0;
    int          m_rel_cyc    = 0;
    int          m_fall_cyc   = 0;
    int          m_last_dv    = 0;
    exp_t        e_pop;

    always @(negedge clk) begin
        if (!rst_n) begin
            m_in_rst     = 1'b1;
            m_prev_ok    = 1'b0;
            m_first_fall = 1'b1;
            m_dv_seen    = 1'b0;
            m_pss        = 1'b1;
            m_pdv        = 1'b0;
        end else begin
            if (m_in_rst) begin
                m_rel_cyc = cyc;
                m_in_rst  = 1'b0;
            end
            if (m_prev_ok) begin
                if (ss) check("sclk_idle", 64'(sclk), 64'd0);
                if (ss != m_pss) check("ss_vs_sclk", 64'({m_psclk, sclk}), 64'd0);
                if (!ss && !m_pss && mosi != m_pmosi) check("mosi_edge", 64'({m_psclk, sclk}), 64'b10);
                if (!data_valid) check("hold", 64'({accel_x, accel_y, accel_z}), 64'(m_pout));
            end
            if (m_pss && !ss) begin
                if (m_first_fall) check("wait_len", 64'(cyc - m_rel_cyc), 64'(POWERUP_WAIT));
                m_first_fall = 1'b0;
                m_fall_cyc   = cyc;
            end
            if (data_valid) begin
                check("dv_width", 64'(m_pdv), 64'd0);
                check("dv_lat", 64'(cyc - m_fall_cyc), 64'(RD_LAT));
                if (m_dv_seen) check("dv_period", 64'(cyc - m_last_dv), 64'(DV_PERIOD));
                m_dv_seen = 1'b1;
                m_last_dv = cyc;
                if (q_exp.size() == 0) begin
                    check("dv_pending", 64'(q_exp.size()), 64'd1);
                end else begin
                    e_pop = q_exp.pop_front();
                    check("accel_x", 64'(accel_x), 64'(e_pop.x));
                    check("accel_y", 64'(accel_y), 64'(e_pop.y));
                    check("accel_z", 64'(accel_z), 64'(e_pop.z));
                end
            end
            m_pss     = ss;
            m_psclk   = sclk;
            m_pmosi   = mosi;
            m_pdv     = data_valid;
            m_pout    = {accel_x, accel_y, accel_z};
            m_prev_ok = 1'b1;
        end
    end

    task automatic wait_reads(input int target, input int budget);
        int n;
        n = 0;
        while (rd_done < target && n < budget) begin
            @(negedge clk);
            n++;
        end
        check("reads_done", 64'(rd_done >= target), 64'd1);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_ss"}, 64'(ss), 64'd1);
        check({tag, "_sclk"}, 64'(sclk), 64'd0);
        check({tag, "_mosi"}, 64'(mosi), 64'd0);
        check({tag, "_x"}, 64'(accel_x), 64'd0);
        check({tag, "_y"}, 64'(accel_y), 64'd0);
        check({tag, "_z"}, 64'(accel_z), 64'd0);
        check({tag, "_dv"}, 64'(data_valid), 64'd0);
    endtask

    initial begin
        int n;
        int target;
        #1 rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        check_reset_outputs("rst");
        rst_n = 1'b1;

        wait_reads(8, 8000);

        // Abort a read partway through byte 5 while sclk is high.
        n = 0;
        do begin
            @(negedge clk);
            #1;
            n++;
        end while (!(s_active && !expect_cfg && nbits == 42 && sclk) && n < 2000);
        check("mid_reset_point", 64'(nbits), 64'd42);
        rst_n = 1'b0;
        #1;
        check_reset_outputs("mid_rst");
        repeat (4) @(posedge clk);
        #2;
        rst_n = 1'b1;

        target = rd_done + 6;
        wait_reads(target, 6000);
        repeat (5) @(negedge clk);
        check("drain", 64'(q_exp.size()), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
